// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Holds the funct3 operation encoding, the control FSM state encoding and
// small decode helpers used by the datapath.
package muldiv_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic is_div_op(input muldiv_op_e op);
        return op[2];
    endfunction

    // rs1 is treated as signed
    function automatic logic is_signed_op(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed (mulhsu keeps rs2 unsigned)
    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute-stage controller and the
// multiply/divide unit.
//   start/flush/op/a/b : controller -> unit
//   result/busy/done   : unit -> controller
interface alu_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic                          start;
    logic                          flush;
    logic [muldiv_pkg::OP_W-1:0]   op;
    logic [XLEN-1:0]               a;
    logic [XLEN-1:0]               b;
    logic [XLEN-1:0]               result;
    logic                          busy;
    logic                          done;

    modport master (
        output start, flush, op, a, b,
        input  result, busy, done
    );

    modport slave (
        input  start, flush, op, a, b,
        output result, busy, done
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : slave side of alu_muldiv_if (start/flush/op/a/b in,
//            result/busy/done out, all outputs registered)
// Multiply is shift-add over {acc,lo}; divide is restoring division over
// {acc=remainder, lo=quotient}. Signs are stripped on entry and restored in FIX.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    muldiv_op_e      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    muldiv_op_e      op_in;
    logic            neg_a_in, neg_b_in;
    logic            div_zero, div_ovf;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (-x) : x;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, datapath step and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;

        op_in    = muldiv_op_e'(bus.op);
        neg_a_in = is_signed_op(op_in) && bus.a[XLEN-1];
        neg_b_in = is_signed_b(op_in) && bus.b[XLEN-1];
        div_zero = is_div_op(op_in) && (bus.b == '0);
        div_ovf  = is_div_op(op_in) && is_signed_op(op_in)
                   && (bus.a == MIN_NEG) && (bus.b == '1);

        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_q};

        prod_fix = (neg_a_q ^ neg_b_q) ? (-{acc_q, lo_q}) : {acc_q, lo_q};
        quot_fix = (neg_a_q ^ neg_b_q) ? (-lo_q) : lo_q;
        // remainder follows the sign of the dividend
        rem_fix  = neg_a_q ? (-acc_q) : acc_q;

        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (bus.start) begin
                        op_d    = op_in;
                        neg_a_d = neg_a_in;
                        neg_b_d = neg_b_in;
                        if (div_zero) begin
                            // op_in[1] selects rem/remu within the divide group
                            result_d = op_in[1] ? bus.a : '1;
                            state_d  = ST_DONE;
                        end else if (div_ovf) begin
                            result_d = op_in[1] ? '0 : bus.a;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_CALC;
                            cnt_d   = CNT_W'(XLEN);
                            acc_d   = '0;
                            if (is_div_op(op_in)) begin
                                lo_d   = mag(bus.a, neg_a_in);
                                opnd_d = mag(bus.b, neg_b_in);
                            end else begin
                                lo_d   = mag(bus.b, neg_b_in);
                                opnd_d = mag(bus.a, neg_a_in);
                            end
                        end
                    end
                end
                ST_CALC: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (is_div_op(op_q)) begin
                        // keep the trial difference only when it did not borrow
                        if (!div_trial[XLEN]) begin
                            acc_d = div_trial[XLEN-1:0];
                            lo_d  = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = div_shift[XLEN-1:0];
                            lo_d  = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (is_div_op(op_q)) begin
                        result_d = op_q[1] ? rem_fix : quot_fix;
                    end else if (op_q == OP_MUL) begin
                        result_d = prod_fix[XLEN-1:0];
                    end else begin
                        result_d = prod_fix[2*XLEN-1:XLEN];
                    end
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (XLEN=32).
module tb_alu_muldiv;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic reset;

    alu_muldiv_if #(.XLEN(XLEN)) bus ();

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] res;
    logic [31:0] prev;
    int          lat;
    int          bcnt;
    int          dcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.flush = 1'b0;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive_start(op, a, b);
    endtask

    // Called in the start cycle (cycle 0); returns at the negedge of the done cycle.
    task automatic wait_done(input int hold, output logic [31:0] r, output int l, output int bc);
        int n;
        n  = 1;
        l  = 0;
        bc = 0;
        r  = 'x;
        @(negedge clk);
        while (l == 0 && n <= 80) begin
            if (n >= hold) bus.start = 1'b0;
            if (n == 1) begin
                bus.a = '0;
                bus.b = '0;
            end
            if (bus.busy) bc++;
            if (bus.done) begin
                l = n;
                r = bus.result;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done) c++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int l;
        int bc;
        issue(op, a, b);
        wait_done(0, r, l, bc);
        chk({tag, "_res"}, r, exp);
        chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;

        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // mul with busy window and done pulse width
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_done(0, res, lat, bcnt);
        chk("mul_res", res, 32'hFFFF_FFEB);
        chk("mul_lat", 32'(lat), 32'd34);
        chk("mul_busy_cycles", 32'(bcnt), 32'd33);
        @(negedge clk);
        chk("mul_done_pulse", 32'(bus.done), 32'd0);
        chk("mul_busy_after", 32'(bus.busy), 32'd0);
        chk("mul_result_held", bus.result, 32'hFFFF_FFEB);

        run("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
        run("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run("remu",   OP_REMU,   32'd100,       32'd7,         32'd2,         34);

        // fast paths
        run("divu_by0", OP_DIVU, 32'd55,        32'd0,         32'hFFFF_FFFF, 1);
        run("rem_by0",  OP_REM,  32'h1234_5678, 32'd0,         32'h1234_5678, 1);
        run("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        run("divu",   OP_DIVU,   32'd100,       32'd7,         32'd14,        34);

        // flush at cycle 10 of a div, restart at cycle 11
        prev = bus.result;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        bus.start = 1'b0;
        dcnt = bus.done ? 1 : 0;
        repeat (9) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.done) dcnt++;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_no_done", 32'(dcnt), 32'd0);
        chk("flush_result_kept", bus.result, prev);
        drive_start(OP_REMU, 32'd100, 32'd7);
        wait_done(0, res, lat, bcnt);
        chk("post_flush_res", res, 32'd2);
        chk("post_flush_lat", 32'(lat), 32'd34);

        // flush and start together: start dropped
        issue(OP_DIVU, 32'd100, 32'd7);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_busy", 32'(bus.busy), 32'd0);
        count_done(40, dcnt);
        chk("flush_start_no_done", 32'(dcnt), 32'd0);
        chk("flush_start_result", bus.result, 32'd2);

        // start held while busy is ignored
        issue(OP_MUL, 32'd3, 32'd5);
        wait_done(20, res, lat, bcnt);
        chk("hold_res", res, 32'd15);
        chk("hold_lat", 32'(lat), 32'd34);
        count_done(40, dcnt);
        chk("hold_single_done", 32'(dcnt), 32'd0);

        // back-to-back start in the DONE cycle
        issue(OP_MUL, 32'd6, 32'd7);
        wait_done(0, res, lat, bcnt);
        chk("b2b_first_res", res, 32'd42);
        drive_start(OP_DIVU, 32'd1000, 32'd9);
        wait_done(0, res, lat, bcnt);
        chk("b2b_second_res", res, 32'd111);
        chk("b2b_second_lat", 32'(lat), 32'd34);

        // asynchronous reset mid-CALC
        issue(OP_MUL, 32'd9, 32'd9);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_result", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(40, dcnt);
        chk("arst_no_done", 32'(dcnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
